hyperbus_trans_arb: RTL
=======================

# hyperbus_trans_arb

Transaction arbiter that shares the single HyperBus PHY transaction/data port between `NumReq` upstream requesters, for example separate AXI read and write front-ends or a register-access master. It captures one transfer at a time, offers it to the PHY, and routes TX, RX and B traffic between the PHY and the owning requester until that transfer completes. It sits directly in front of the PHY `trans_*`, `tx_*`, `rx_*` and `b_*` ports.

## Interface
- `NumReq`, default 2: number of requesters, ≥2.
- `NumChips`, default 2: chip-select width.
- `clk_i` in, 1: clock.
- `rst_ni` in, 1: reset, asynchronous, active-low.
- `req_valid_i` in, NumReq: transfer request valid per requester.
- `req_ready_o` out, NumReq: one-hot acceptance pulse.
- `req_tf_i` in, NumReq × `hyper_tf_t`: transfer descriptor per requester.
- `req_cs_i` in, NumReq × NumChips: chip select per requester.
- `trans_valid_o` out, 1 / `trans_ready_i` in, 1: PHY transaction handshake.
- `trans_o` out, `hyper_tf_t` / `trans_cs_o` out, NumChips: registered descriptor and chip select.
- `req_tx_valid_i` in, NumReq / `req_tx_ready_o` out, NumReq: per-requester TX handshake.
- `req_tx_data_i` in, NumReq×16 / `req_tx_strb_i` in, NumReq×2 / `req_tx_last_i` in, NumReq: per-requester TX payload.
- `tx_valid_o`, `tx_data_o[15:0]`, `tx_strb_o[1:0]`, `tx_last_o` out / `tx_ready_i` in: TX port to the PHY.
- `rx_valid_i`, `rx_data_i[15:0]`, `rx_error_i`, `rx_last_i` in / `rx_ready_o` out: RX port from the PHY.
- `req_rx_valid_o` out, NumReq / `req_rx_ready_i` in, NumReq: per-requester RX handshake.
- `req_rx_data_o` out, 16 / `req_rx_error_o` out, 1 / `req_rx_last_o` out, 1: RX payload, broadcast to all requesters.
- `b_valid_i`, `b_error_i` in / `b_ready_o` out: B response port from the PHY.
- `req_b_valid_o` out, NumReq / `req_b_ready_i` in, NumReq / `req_b_error_o` out, 1: per-requester B response.

## Operation
- FSM states: `Idle`, `Offer`, `Busy`. Registers: `owner_q` (index), `tf_q`, `cs_q`, `rr_q` (round-robin pointer).
- **Idle**
  - The winner is the first requester with `req_valid_i` set, searching from `rr_q` upward with wrap-around.
  - Assert `req_ready_o[winner]`; in the same cycle capture `req_tf_i`/`req_cs_i` into `tf_q`/`cs_q` and set `owner_q` ← winner.
  - Update `rr_q` ← (winner+1) mod NumReq, then go to `Offer`.
  - If no requester is valid, stay in `Idle`.
- **Offer**
  - `trans_valid_o`=1; `trans_o`/`trans_cs_o` are driven from `tf_q`/`cs_q`, which hold stable while waiting.
  - On `trans_ready_i`, go to `Busy`.
- **Busy**, completion tracking:
  - Write (`tf_q.write`=1): completes on `b_valid_i & b_ready_o`.
  - Read: completes on `rx_valid_i & rx_ready_o & rx_last_i`.
  - On completion, go to `Idle`.
  - A read that the PHY force-terminates on its burst limit still ends with exactly one `rx_last_i`. The arbiter relies only on that `rx_last_i`.
- **Routing**, valid in `Offer` and `Busy`:
  - TX: `tx_*_o` ← owner's request; `req_tx_ready_o[owner]` = `tx_ready_i`.
  - RX: `req_rx_valid_o[owner]` = `rx_valid_i`; `rx_ready_o` = `req_rx_ready_i[owner]`.
  - B: `req_b_valid_o[owner]` = `b_valid_i`; `b_ready_o` = `req_b_ready_i[owner]`.
  - Non-owner valid and ready bits are 0. In `Idle`, all routed valid and ready bits are 0.
- Descriptors are passed through unmodified; burst and address are not checked.

## Timing
- Reset values: all outputs 0, state `Idle`, `rr_q`=0, `owner_q`=0, `tf_q`/`cs_q`=0.
- Latency: 1 cycle from a `req_ready_o` pulse to `trans_valid_o`=1. The back-to-back minimum is 1 idle cycle between completion and the next `req_ready_o`.
- `req_ready_o` depends combinationally on `req_valid_i` (Idle only). `trans_valid_o` is registered-state only.
- The routing paths are purely combinational.
- A request that drops `req_valid_i` before being granted is never captured. A requester must hold `req_tf_i` stable while valid.
- When completion and a new request occur in the same cycle, the new request is arbitrated in the following `Idle` cycle.
- Reset mid-transfer returns to `Idle` immediately; the PHY is reset with the arbiter.

## Configuration
- `HYPERBUS_ARB_FIXED_PRIO_EN` defined: fixed priority, where the lowest valid index always wins and `rr_q` is not implemented.
- `HYPERBUS_ARB_FIXED_PRIO_EN` undefined (default): round-robin as described above.

## Test plan
- Reset, then no requests → all outputs 0 and state stays `Idle` for 10 cycles.
- Req0 issues a read with burst 4 while the PHY returns 4 RX words, last on word 4 → `req_rx_valid_o`=2'b01 for each word, return to `Idle` after the last handshake, next grant possible 1 cycle later.
- Req1 issues a write with burst 2 and `req_tx_strb_i`=2'b11 → `tx_*` mirrors req1, `req_b_valid_o`=2'b10 on B, `req_b_error_o`=0.
- Req0 and req1 are both continuously valid (round-robin build) → grants alternate 0, 1, 0, 1 over 4 transfers. With `HYPERBUS_ARB_FIXED_PRIO_EN` → all 4 grants go to 0.
- Hold `trans_ready_i`=0 for 5 cycles in `Offer` → `trans_o` is stable and no second `req_ready_o` is issued.
- Assert reset during `Busy` of a read → `req_rx_valid_o`=0 and `trans_valid_o`=0 immediately, `rr_q`=0 after release.

Source files
------------

// File: rtl/hyperbus_trans_arb.sv
// rtl/hyperbus_trans_arb.sv - shares one HyperBus PHY transaction/data port between NumReq requesters.
// HYPERBUS_ARB_FIXED_PRIO_EN: lowest valid index always wins (no round-robin pointer).

package hyperbus_trans_arb_pkg;
    typedef struct packed {
        logic        write;
        logic        address_space;
        logic        burst_type;
        logic [31:0] address;
        logic [15:0] burst;
    } hyper_tf_t;
endpackage

module hyperbus_trans_arb
    import hyperbus_trans_arb_pkg::*;
#(
    parameter int unsigned NumReq   = 2,
    parameter int unsigned NumChips = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    // transfer requests
    input  logic [NumReq-1:0]                  req_valid_i,
    output logic [NumReq-1:0]                  req_ready_o,
    input  hyper_tf_t [NumReq-1:0]             req_tf_i,
    input  logic [NumReq-1:0][NumChips-1:0]    req_cs_i,
    // PHY transaction port
    output logic                               trans_valid_o,
    input  logic                               trans_ready_i,
    output hyper_tf_t                          trans_o,
    output logic [NumChips-1:0]                trans_cs_o,
    // TX from requesters to PHY
    input  logic [NumReq-1:0]                  req_tx_valid_i,
    output logic [NumReq-1:0]                  req_tx_ready_o,
    input  logic [NumReq-1:0][15:0]            req_tx_data_i,
    input  logic [NumReq-1:0][1:0]             req_tx_strb_i,
    input  logic [NumReq-1:0]                  req_tx_last_i,
    output logic                               tx_valid_o,
    output logic [15:0]                        tx_data_o,
    output logic [1:0]                         tx_strb_o,
    output logic                               tx_last_o,
    input  logic                               tx_ready_i,
    // RX from PHY to requesters
    input  logic                               rx_valid_i,
    input  logic [15:0]                        rx_data_i,
    input  logic                               rx_error_i,
    input  logic                               rx_last_i,
    output logic                               rx_ready_o,
    output logic [NumReq-1:0]                  req_rx_valid_o,
    input  logic [NumReq-1:0]                  req_rx_ready_i,
    output logic [15:0]                        req_rx_data_o,
    output logic                               req_rx_error_o,
    output logic                               req_rx_last_o,
    // B response from PHY to requesters
    input  logic                               b_valid_i,
    input  logic                               b_error_i,
    output logic                               b_ready_o,
    output logic [NumReq-1:0]                  req_b_valid_o,
    input  logic [NumReq-1:0]                  req_b_ready_i,
    output logic                               req_b_error_o
);

    localparam int unsigned IdxW = $clog2(NumReq);

    typedef enum logic [1:0] {
        Idle,
        Offer,
        Busy
    } state_e;

    state_e              state_q;
    logic [IdxW-1:0]     owner_q;
    hyper_tf_t           tf_q;
    logic [NumChips-1:0] cs_q;
`ifndef HYPERBUS_ARB_FIXED_PRIO_EN
    logic [IdxW-1:0]     rr_q;
`endif

    logic            found;
    logic [IdxW-1:0] winner;
    logic            in_xfer;
    logic            done;

    // Winner selection: lowest index (fixed) or first valid at/after rr_q (round-robin).
    always_comb begin
        found  = 1'b0;
        winner = '0;
`ifdef HYPERBUS_ARB_FIXED_PRIO_EN
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                found  = 1'b1;
                winner = IdxW'(i);
            end
        end
`else
        for (int k = 0; k < NumReq; k++) begin
            int idx;
            idx = int'(rr_q) + k;
            if (idx >= int'(NumReq)) begin
                idx = idx - int'(NumReq);
            end
            if (!found && req_valid_i[idx]) begin
                found  = 1'b1;
                winner = IdxW'(idx);
            end
        end
`endif
    end

    always_comb begin
        req_ready_o = '0;
        if (state_q == Idle && found) begin
            req_ready_o[winner] = 1'b1;
        end
    end

    assign in_xfer = (state_q != Idle);

    // Data-path routing to and from the current owner; everything is quiet in Idle.
    always_comb begin
        req_tx_ready_o = '0;
        req_rx_valid_o = '0;
        req_b_valid_o  = '0;
        tx_valid_o     = 1'b0;
        tx_data_o      = '0;
        tx_strb_o      = '0;
        tx_last_o      = 1'b0;
        rx_ready_o     = 1'b0;
        req_rx_data_o  = '0;
        req_rx_error_o = 1'b0;
        req_rx_last_o  = 1'b0;
        b_ready_o      = 1'b0;
        req_b_error_o  = 1'b0;
        if (in_xfer) begin
            tx_valid_o              = req_tx_valid_i[owner_q];
            tx_data_o               = req_tx_data_i[owner_q];
            tx_strb_o               = req_tx_strb_i[owner_q];
            tx_last_o               = req_tx_last_i[owner_q];
            req_tx_ready_o[owner_q] = tx_ready_i;
            req_rx_valid_o[owner_q] = rx_valid_i;
            rx_ready_o              = req_rx_ready_i[owner_q];
            req_rx_data_o           = rx_data_i;
            req_rx_error_o          = rx_error_i;
            req_rx_last_o           = rx_last_i;
            req_b_valid_o[owner_q]  = b_valid_i;
            b_ready_o               = req_b_ready_i[owner_q];
            req_b_error_o           = b_error_i;
        end
    end

    // A forced burst-limit termination still ends on a single rx_last, so that is all we watch.
    assign done = tf_q.write ? (b_valid_i & req_b_ready_i[owner_q])
                             : (rx_valid_i & req_rx_ready_i[owner_q] & rx_last_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= Idle;
            owner_q       <= '0;
            tf_q          <= '0;
            cs_q          <= '0;
            trans_valid_o <= 1'b0;
`ifndef HYPERBUS_ARB_FIXED_PRIO_EN
            rr_q          <= '0;
`endif
        end else begin
            case (state_q)
                Idle: begin
                    if (found) begin
                        tf_q          <= req_tf_i[winner];
                        cs_q          <= req_cs_i[winner];
                        owner_q       <= winner;
                        trans_valid_o <= 1'b1;
                        state_q       <= Offer;
`ifndef HYPERBUS_ARB_FIXED_PRIO_EN
                        rr_q <= (winner == IdxW'(NumReq - 1)) ? '0 : winner + 1'b1;
`endif
                    end
                end
                Offer: begin
                    if (trans_ready_i) begin
                        trans_valid_o <= 1'b0;
                        state_q       <= Busy;
                    end
                end
                Busy: begin
                    if (done) begin
                        state_q <= Idle;
                    end
                end
                default: begin
                    trans_valid_o <= 1'b0;
                    state_q       <= Idle;
                end
            endcase
        end
    end

    assign trans_o    = tf_q;
    assign trans_cs_o = cs_q;

endmodule
